// File: rtl/ram.sv
// Single-port RAM: synchronous write, combinational read, asynchronous clear on RST_N.
// Optional macro RAM_WRITE_BYPASS_EN selects write-first read behaviour (default is read-first).
module ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [WIDTH-1:0]      WD,
  output logic [WIDTH-1:0]      RD
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             in_range;
  logic             wr_en;

  assign in_range = ({1'b0, ADDRESS} < DEPTH_W);
  assign wr_en    = WE && in_range;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[ADDRESS] <= WD;
    end
  end

  // Out-of-range reads are muxed to zero so no undefined index reaches RD.
  always_comb begin
    RD = '0;
    if (!RST_N) begin
      RD = '0;
`ifdef RAM_WRITE_BYPASS_EN
    end else if (wr_en) begin
      RD = WD;
`endif
    end else if (in_range) begin
      RD = mem_q[ADDRESS];
    end
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram (DEPTH=200, ADDR_WIDTH=8): array model plus directed literal checks.
module tb_ram;
  localparam int WIDTH = 32;
  localparam int DEPTH = 200;
  localparam int AW    = 8;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic            WE = 1'b0;
  logic [AW-1:0]   ADDRESS = '0;
  logic [WIDTH-1:0] WD = '0;
  logic [WIDTH-1:0] RD;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RAM_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .ADDRESS(ADDRESS), .WD(WD), .RD(RD)
  );

  always #5 CLK = ~CLK;

  // Reference contents: plain word array indexed by address value.
  logic [WIDTH-1:0] model [256];
  initial for (int i = 0; i < 256; i++) model[i] = '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 256; i++) model[i] <= '0;
    end else if (WE && int'(ADDRESS) < DEPTH) begin
      model[ADDRESS] <= WD;
    end
  end

  function automatic logic [WIDTH-1:0] expect_rd();
    if (!RST_N) return '0;
    if (int'(ADDRESS) >= DEPTH) return '0;
    if (BYPASS && WE) return WD;
    return model[ADDRESS];
  endfunction

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: addr=%0d got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
               nm, ADDRESS, act, act, exp, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if ($time > 5) check("rd_model", RD, expect_rd());
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wr(input int a, input int d);
    step();
    WE = 1'b1; ADDRESS = AW'(a); WD = WIDTH'(d);
    step();
    WE = 1'b0;
  endtask

  task automatic rd_check(input string nm, input int a, input int exp);
    ADDRESS = AW'(a);
    #1;
    check(nm, RD, WIDTH'(exp));
  endtask

  initial begin
    logic [WIDTH-1:0] first_val;
    // Reset then idle
    #1 RST_N = 1'b0;
    step(); step();
    RST_N = 1'b1;
    step();
    rd_check("idle_a0", 0, 0);
    rd_check("idle_a1", 1, 0);
    rd_check("idle_a100", 100, 0);
    rd_check("idle_a255", 255, 0);

    // Sequential fill and readback
    for (int a = 1; a <= 100; a++) wr(a, 1000 + a);
    step();
    for (int a = 1; a <= 100; a++) begin
      ADDRESS = AW'(a);
      #1;
      if (a == 1) first_val = RD;
      check("readback", RD, WIDTH'(1000 + a));
    end
    check("readback_lit1", first_val, 32'd1001);
    rd_check("readback_a100", 100, 1100);
    rd_check("readback_a0", 0, 0);
    rd_check("readback_a101", 101, 0);

    // Same-address collision at 5 holding 7
    wr(5, 7);
    step();
    rd_check("coll_hold", 5, 7);
    WE = 1'b1; WD = 32'd9;
    #1;
    check("coll_before", RD, BYPASS ? 32'd9 : 32'd7);
    step();
    WE = 1'b0;
    #1;
    check("coll_after", RD, 32'd9);

    // Out-of-range write
    wr(210, 32'hDEAD);
    rd_check("oor_a210", 210, 0);
    rd_check("oor_a82", 82, 1082);
    rd_check("oor_a10", 10, 1010);
    rd_check("oor_a199", 199, 0);
    WE = 1'b1; ADDRESS = AW'(210); WD = 32'hDEAD;
    #1;
    check("oor_bypass", RD, 32'd0);
    step();
    WE = 1'b0;

    // WE=0 hold
    wr(3, 50);
    ADDRESS = AW'(3); WD = 32'd77;
    for (int c = 0; c < 5; c++) begin
      step();
      check("we0_hold", RD, 32'd50);
    end

    // Reset mid-operation
    for (int a = 1; a <= 10; a++) wr(a, a);
    rd_check("pre_rst_a7", 7, 7);
    step();
    ADDRESS = AW'(5);
    #1 RST_N = 1'b0;
    #1 check("rst_async", RD, 32'd0);
    #3 RST_N = 1'b1;
    step();
    for (int a = 1; a <= 10; a++) rd_check("post_rst", a, 0);
    rd_check("post_rst_a50", 50, 0);

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
